// File: rtl/pt_validator_if.sv
// pt_validator_if -- handshake and plaintext-RAM read bus of the plaintext validator.
//   en        : start request (controller -> validator)
//   rdy       : validator idle, results valid (validator -> controller)
//   pt_addr   : plaintext RAM read address (validator -> RAM)
//   pt_rddata : plaintext RAM read data, one cycle behind the address (RAM -> validator)
//   valid     : every message byte accepted
//   err_idx   : index of the first rejected byte, 0 if none
//   len       : length byte read from address 0
// modport slave  : the validator
// modport master : the controller plus plaintext RAM side
interface pt_validator_if;
    logic       en;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       valid;
    logic [7:0] err_idx;
    logic [7:0] len;

    modport slave (
        input  en, pt_rddata,
        output rdy, pt_addr, valid, err_idx, len
    );

    modport master (
        output en, pt_rddata,
        input  rdy, pt_addr, valid, err_idx, len
    );
endinterface

// File: rtl/pt_validator.sv
// pt_validator -- scans the length-prefixed plaintext buffer written by the PRGA
// stage and reports whether every message byte is plausible text.
// Buffer layout: byte 0 = length n, bytes 1..n = message.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active high
//   bus : pt_validator_if.slave (en/rdy handshake, RAM read port, results)
// Parameters:
//   LO, HI : inclusive accepted byte range (unsigned)
// Build option:
//   PT_VALIDATOR_LOWER_EN : when defined, only space and 'a'..'z' are accepted
//                           and LO/HI are ignored. Timing is unchanged.
// Each RAM read takes three cycles (address, RAM latency, check), so a scan
// keeps rdy low for 3 + 3k cycles, k = number of message bytes read.
module pt_validator #(
    parameter logic [7:0] LO = 8'h20,
    parameter logic [7:0] HI = 8'h7E
) (
    input  logic           clk,
    input  logic           rst,
    pt_validator_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_ADDR,
        LEN_WAIT,
        LEN_CHECK,
        BYTE_ADDR,
        BYTE_WAIT,
        BYTE_CHECK
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] idx, idx_nxt;
    logic [7:0] len_q, len_nxt;
    logic [7:0] err_q, err_nxt;
    logic       valid_q, valid_nxt;
    logic       byte_ok;

    // Character class test on the byte returned by the RAM.
`ifdef PT_VALIDATOR_LOWER_EN
    always_comb begin
        byte_ok = (bus.pt_rddata == 8'h20) ||
                  ((bus.pt_rddata >= 8'h61) && (bus.pt_rddata <= 8'h7A));
    end
`else
    always_comb begin
        byte_ok = (bus.pt_rddata >= LO) && (bus.pt_rddata <= HI);
    end
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len_q;
        err_nxt   = err_q;
        valid_nxt = valid_q;
        case (state)
            IDLE: begin
                if (bus.en) state_nxt = LEN_ADDR;
            end
            LEN_ADDR:  state_nxt = LEN_WAIT;
            LEN_WAIT:  state_nxt = LEN_CHECK;
            LEN_CHECK: begin
                len_nxt = bus.pt_rddata;
                idx_nxt = 8'd1;
                if (bus.pt_rddata == 8'd0) begin
                    // Empty message is trivially plausible.
                    valid_nxt = 1'b1;
                    err_nxt   = 8'd0;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BYTE_ADDR;
                end
            end
            BYTE_ADDR: state_nxt = BYTE_WAIT;
            BYTE_WAIT: state_nxt = BYTE_CHECK;
            BYTE_CHECK: begin
                if (!byte_ok) begin
                    // Early exit: the key is already known to be wrong.
                    valid_nxt = 1'b0;
                    err_nxt   = idx;
                    state_nxt = IDLE;
                end else if (idx == len_q) begin
                    // Stopping at idx == len keeps idx from wrapping at len = 255.
                    valid_nxt = 1'b1;
                    err_nxt   = 8'd0;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = BYTE_ADDR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 8'd0;
            len_q   <= 8'd0;
            err_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            len_q   <= len_nxt;
            err_q   <= err_nxt;
            valid_q <= valid_nxt;
        end
    end

    // The address is a function of registered state only, so the RAM sees a
    // stable value for the whole three-cycle read.
    assign bus.pt_addr = ((state == BYTE_ADDR) || (state == BYTE_WAIT) ||
                          (state == BYTE_CHECK)) ? idx : 8'd0;
    assign bus.rdy     = (state == IDLE);
    assign bus.valid   = valid_q;
    assign bus.err_idx = err_q;
    assign bus.len     = len_q;

endmodule

// File: tb/tb_pt_validator.sv
module tb_pt_validator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pt_validator_if bus ();

    pt_validator #(.LO(8'h20), .HI(8'h7E)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous plaintext RAM model: data follows the address by one edge.
    logic [7:0] mem [256];
    always @(posedge clk) bus.pt_rddata <= mem[bus.pt_addr];

    typedef struct {
        string           name;
        logic [7:0]      n;
        logic [0:7][7:0] b;      // message bytes 1..8
        logic [7:0]      fill;   // bytes 9..n
        logic            ev;     // expected valid
        logic [7:0]      ee;     // expected err_idx
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] e;
        logic [7:0] l;
        int         cyc;
        int         last;
        int         cnt;
    } exp_t;

    exp_t sb [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge. Loads RAM, starts a scan, measures busy cycles and
    // the distinct address sequence, then scores the result.
    task automatic run_scan(input vec_t v, input bit toggle);
        exp_t e, g;
        int   k, cyc, cnt, last;
        bit   done;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = v.n;
        for (int j = 1; j <= int'(v.n); j++) mem[j] = (j <= 8) ? v.b[j-1] : v.fill;
        k      = v.ev ? int'(v.n) : int'(v.ee);
        e.v    = v.ev;
        e.e    = v.ev ? 8'd0 : v.ee;
        e.l    = v.n;
        e.cyc  = 3 + 3 * k;
        e.last = k;
        e.cnt  = k + 1;
        sb.push_back(e);
        bus.en = 1'b1;
        cyc = 0; cnt = 0; last = -1; done = 0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (bus.rdy) begin
                done   = 1;
                bus.en = 1'b0;
            end else begin
                cyc++;
                if (int'(bus.pt_addr) != last) begin
                    cnt++;
                    last = int'(bus.pt_addr);
                end
                bus.en = toggle && t[0];
            end
        end
        g = sb.pop_front();
        if (!done) begin
            bus.en = 1'b0;
            chk({v.name, " timeout"}, 0, 1);
        end else begin
            chk({v.name, " valid"},   int'(bus.valid),   int'(g.v));
            chk({v.name, " err_idx"}, int'(bus.err_idx), int'(g.e));
            chk({v.name, " len"},     int'(bus.len),     int'(g.l));
            chk({v.name, " busy"},    cyc,               g.cyc);
            chk({v.name, " lastaddr"}, last,             g.last);
            chk({v.name, " addrcnt"}, cnt,               g.cnt);
        end
    endtask

    vec_t tbl [7];

    initial begin
        tbl[0] = '{"abc",   8'd3,  {8'h61, 8'h62, 8'h63, 40'h0}, 8'h00, 1'b1, 8'd0};
`ifdef PT_VALIDATOR_LOWER_EN
        tbl[1] = '{"early", 8'd5,  {8'h41, 8'h07, 8'h42, 8'h43, 8'h44, 24'h0}, 8'h00, 1'b0, 8'd1};
        tbl[3] = '{"edge_ok", 8'd2, {8'h20, 8'h7E, 48'h0}, 8'h00, 1'b0, 8'd2};
        tbl[5] = '{"aB",    8'd2,  {8'h61, 8'h42, 48'h0}, 8'h00, 1'b0, 8'd2};
`else
        tbl[1] = '{"early", 8'd5,  {8'h41, 8'h07, 8'h42, 8'h43, 8'h44, 24'h0}, 8'h00, 1'b0, 8'd2};
        tbl[3] = '{"edge_ok", 8'd2, {8'h20, 8'h7E, 48'h0}, 8'h00, 1'b1, 8'd0};
        tbl[5] = '{"aB",    8'd2,  {8'h61, 8'h42, 48'h0}, 8'h00, 1'b1, 8'd0};
`endif
        tbl[2] = '{"empty", 8'd0,  64'h0, 8'h00, 1'b1, 8'd0};
        tbl[4] = '{"edge_bad", 8'd2, {8'h1F, 8'h7F, 48'h0}, 8'h00, 1'b0, 8'd1};
        tbl[6] = '{"len255", 8'd255, {8{8'h61}}, 8'h7A, 1'b1, 8'd0};

        bus.en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset rdy",     int'(bus.rdy),     1);
        chk("reset valid",   int'(bus.valid),   0);
        chk("reset err_idx", int'(bus.err_idx), 0);
        chk("reset len",     int'(bus.len),     0);
        chk("reset pt_addr", int'(bus.pt_addr), 0);

        for (int i = 0; i < 7; i++) run_scan(tbl[i], 1'b0);

        // en toggled while busy must not restart or disturb the scan.
        run_scan(tbl[5], 1'b1);
        run_scan(tbl[1], 1'b1);

        // Reset during the third message byte of a 16-byte scan.
        for (int i = 0; i < 256; i++) mem[i] = 8'h61;
        mem[0] = 8'h10;
        bus.en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (t == 9) chk("midrst busy", int'(bus.rdy), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst rdy",     int'(bus.rdy),     1);
        chk("midrst valid",   int'(bus.valid),   0);
        chk("midrst err_idx", int'(bus.err_idx), 0);
        chk("midrst len",     int'(bus.len),     0);
        chk("midrst pt_addr", int'(bus.pt_addr), 0);
        begin
            vec_t v16;
            v16 = '{"after_rst", 8'd16, {8{8'h61}}, 8'h62, 1'b1, 8'd0};
            run_scan(v16, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pt_validator.md
Name: pt_validator

Overview:
- Reads back the plaintext buffer that the PRGA stage writes and decides whether the decrypted message is plausible text.
- Buffer is length-prefixed: byte 0 holds the length n, bytes 1..n hold the message.
- Sits between the PRGA stage and the key-search controller. Its valid/rdy result tells the controller to accept the current key or try the next one.
- It is the consumer ("reader") of the PRGA stage's pt_addr/pt_wrdata write interface.

Parameters:
- LO, 8'h20, lowest accepted byte value (inclusive)
- HI, 8'h7E, highest accepted byte value (inclusive)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  start request; accepted only on a clock edge where rdy=1
- rdy  output  1  high when idle and able to accept en; results valid while high
- pt_addr  output  8  read address into plaintext RAM
- pt_rddata  input  8  RAM read data; synchronous RAM, data follows the registered address
- valid  output  1  1 = every message byte lies in the accepted range
- err_idx  output  8  index (1..n) of the first rejected byte; 0 if none
- len  output  8  length byte read at address 0, captured at end of the length read

Behaviour:
- Reset: on a clk edge with rst=1, state goes to IDLE with rdy=1, valid=0, err_idx=0, len=0, pt_addr=0. Reset overrides en.
- Reset mid-operation: the scan aborts, no result is written, and the next cycle is IDLE.
- States: IDLE, LEN_ADDR, LEN_WAIT, LEN_CHECK, BYTE_ADDR, BYTE_WAIT, BYTE_CHECK.
- IDLE: rdy=1, outputs hold their last result.
  - en=1 at an edge moves to LEN_ADDR; rdy=0 from the next cycle.
  - en=0 stays in IDLE.
- LEN_ADDR, LEN_WAIT, LEN_CHECK: pt_addr=0 for all three cycles.
  - In LEN_CHECK, len <= pt_rddata and index i <= 1.
  - If pt_rddata==0: valid<=1, err_idx<=0, go to IDLE.
  - Otherwise go to BYTE_ADDR.
- BYTE_ADDR, BYTE_WAIT, BYTE_CHECK: pt_addr=i, held constant across all three cycles.
  - In BYTE_CHECK, a byte is accepted when LO <= pt_rddata <= HI (unsigned compare).
  - Rejected byte: valid<=0, err_idx<=i, go to IDLE (early exit; remaining bytes are not read).
  - Accepted byte and i==len: valid<=1, err_idx<=0, go to IDLE.
  - Accepted byte otherwise: i<=i+1, go to BYTE_ADDR.
- Latency: rdy is low for exactly 3+3k cycles, where k = number of bytes read (k=n on success, k=err_idx on failure).
- Width and wrap:
  - i is 8 bits. len=255 reads addresses 1..255, and i never wraps because it stops at i==len.
  - pt_addr never exceeds 8'hFF.
- en while rdy=0 is ignored; it is neither queued nor restarts the scan.
- en held high continuously: a new scan starts on the first edge rdy is high again. Results remain readable for that one cycle.
- valid, err_idx and len change only in LEN_CHECK/BYTE_CHECK or on reset.
- The block never writes RAM and has no write-enable output.

Optional Feature:
- Macro: PT_VALIDATOR_LOWER_EN.
- Defined: the accepted set is exactly 8'h20 (space) plus 8'h61..8'h7A (a-z). LO and HI are ignored.
- Undefined: the accepted set is LO..HI as parameterised. Timing and FSM are identical either way.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles then 0 -> rdy=1, valid=0, err_idx=0, len=0, pt_addr=0.
- Valid message: RAM = {8'h03, "a", "b", "c"}, pulse en -> pt_addr sequence 0,1,2,3; rdy low for 12 cycles; then rdy=1, valid=1, err_idx=0, len=8'h03.
- Early rejection: RAM = {8'h05, 8'h41, 8'h07, 8'h42, 8'h43, 8'h44} -> stops after addr 2; rdy low for 9 cycles; valid=0, err_idx=2, len=5; addresses 3..5 are never driven.
- Empty and boundary cases:
  - Length 8'h00 -> rdy low for 3 cycles; valid=1, err_idx=0.
  - Length 8'h02 with data {8'h20, 8'h7E} -> valid=1.
  - Length 8'h02 with data {8'h1F, 8'h7F} -> valid=0, err_idx=1.
- Reset mid-scan: length 8'h10, assert rst during the 3rd byte -> next cycle rdy=1, valid=0, err_idx=0. A fresh en then completes normally.
- Ignored en plus macro: toggle en while rdy=0 -> no restart, and the address sequence is unchanged.
  - With PT_VALIDATOR_LOWER_EN, data "aB" -> valid=0, err_idx=2.
  - Without the macro, the same data -> valid=1.
